// File: rtl/exprom_ctrl.sv
// Expansion-ROM array controller.
// Arbitrates the PCI target path and the loader port onto a 512x32 array made
// of four byte-lane RAMs sharing one address, enable and write strobe. Partial
// target writes become read-modify-write. Also applies the ROM BAR enable and
// the target write-protect policy. Every output is registered.
module exprom_ctrl #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rom_bar_en,
  input  logic          write_protect,
  input  logic          t_req,
  input  logic          t_we,
  input  logic [AW-1:0] t_addr,
  input  logic [3:0]    t_be,
  input  logic [DW-1:0] t_wdata,
  output logic          t_ack,
  output logic [DW-1:0] t_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_ack,
  output logic [DW-1:0] l_rdata,
  output logic [AW-1:0] rom_address,
  output logic [DW-1:0] rom_dinp,
  output logic          rom_wren,
  output logic          rom_enable,
  input  logic [DW-1:0] rom_dout,
  output logic          busy,
  output logic          wp_violation
);

  localparam int LW = DW / 4;  // width of one byte lane

  typedef enum logic [2:0] {
    IDLE, RD, RDW, MRD, MRDW, MWR, WR, DONE
  } state_t;

  state_t        state;
  logic          gnt_t;     // current grant belongs to the target
  logic          prio_t;    // on a tie, the target wins next
  logic [DW-1:0] lat_data;  // target write data held for the merge
  logic [3:0]    lat_be;    // target byte enables held for the merge
  logic          pick_t;
  logic [DW-1:0] merged;

  // Round-robin pick: the target wins when it is alone or holds priority.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    pick_t = 1'b0;
    if (t_req && (!l_req || prio_t)) pick_t = 1'b1;
  end

  // Byte-lane merge of the old word with the new target data.
  always_comb begin
    merged = rom_dout;
    for (int k = 0; k < 4; k++) begin
      if (lat_be[k]) merged[k*LW +: LW] = lat_data[k*LW +: LW];
    end
  end

  // Sequencer: arbitration, ROM strobes, read capture and ack generation.
  always_ff @(posedge clk) begin
    // NOTE: state and output registers use non-blocking assignments only, so
    // every read inside this block sees the value from before the edge.
    if (!rst_n) begin
      // NOTE: the data registers are reset too, because every output must read
      // zero after reset; there is no memory array inside this block.
      state        <= IDLE;
      gnt_t        <= 1'b0;
      prio_t       <= 1'b1;
      lat_data     <= '0;
      lat_be       <= '0;
      t_ack        <= 1'b0;
      l_ack        <= 1'b0;
      t_rdata      <= '0;
      l_rdata      <= '0;
      rom_address  <= '0;
      rom_dinp     <= '0;
      rom_wren     <= 1'b0;
      rom_enable   <= 1'b0;
      busy         <= 1'b0;
      wp_violation <= 1'b0;
    end else begin
      t_ack        <= 1'b0;
      l_ack        <= 1'b0;
      wp_violation <= 1'b0;
      case (state)
        IDLE: begin
          if (t_req || l_req) begin
            gnt_t  <= pick_t;
            prio_t <= !pick_t;
            busy   <= 1'b1;
            if (pick_t) begin
              if (!rom_bar_en) begin
                t_rdata <= '0;
                t_ack   <= 1'b1;
                state   <= DONE;
              end else if (t_we && write_protect) begin
                wp_violation <= 1'b1;
                t_ack        <= 1'b1;
                state        <= DONE;
              end else if (t_we && (t_be == 4'h0)) begin
                t_ack <= 1'b1;
                state <= DONE;
              end else begin
                rom_address <= t_addr;
                rom_enable  <= 1'b1;
                lat_data    <= t_wdata;
                lat_be      <= t_be;
                if (!t_we) begin
                  state <= RD;
                end else if (t_be == 4'hF) begin
                  rom_wren <= 1'b1;
                  rom_dinp <= t_wdata;
                  state    <= WR;
                end else begin
                  state <= MRD;
                end
              end
            end else begin
              rom_address <= l_addr;
              rom_enable  <= 1'b1;
              if (l_we) begin
                rom_wren <= 1'b1;
                rom_dinp <= l_wdata;
                state    <= WR;
              end else begin
                state <= RD;
              end
            end
          end
        end
        RD: begin
          rom_enable <= 1'b0;
          state      <= RDW;
        end
        RDW: begin
          if (gnt_t) t_rdata <= rom_dout;
          else       l_rdata <= rom_dout;
          t_ack <= gnt_t;
          l_ack <= !gnt_t;
          state <= DONE;
        end
        MRD: begin
          rom_enable <= 1'b0;
          state      <= MRDW;
        end
        MRDW: begin
          rom_enable <= 1'b1;
          rom_wren   <= 1'b1;
          rom_dinp   <= merged;
          state      <= MWR;
        end
        MWR, WR: begin
          rom_enable <= 1'b0;
          rom_wren   <= 1'b0;
          t_ack      <= gnt_t;
          l_ack      <= !gnt_t;
          state      <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/exprom_ctrl.md
Name: exprom_ctrl

Overview:
- Sequences and arbitrates the 512x32 expansion-ROM array, which is built from four 8-bit byte-lane RAMs that share one address, one enable and one write strobe.
- Two requesters share the array:
  - the PCI target path, which reads and writes the expansion ROM window;
  - a loader/management port, which writes or reads back the ROM image.
- Because the array has a single write strobe, partial byte-enable target writes are done as read-modify-write (RMW).
- The block also applies the ROM BAR enable and the write-protect policy.

Parameters:
- AW, 9, ROM word-address width (512 words).
- DW, 32, data width (4 byte lanes).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- rom_bar_en  in  1  expansion ROM BAR enable bit from config space
- write_protect  in  1  1 = target writes are dropped
- t_req  in  1  target request; held until t_ack
- t_we  in  1  target write (1) / read (0)
- t_addr  in  AW  target word address
- t_be  in  4  target byte enables; bit0 = dinp[7:0]
- t_wdata  in  DW  target write data
- t_ack  out  1  one-cycle completion pulse
- t_rdata  out  DW  target read data, valid while t_ack = 1
- l_req  in  1  loader request; held until l_ack
- l_we  in  1  loader write (1) / read (0)
- l_addr  in  AW  loader word address
- l_wdata  in  DW  loader write data (always a full word)
- l_ack  out  1  one-cycle completion pulse
- l_rdata  out  DW  loader read data, valid while l_ack = 1
- rom_address  out  AW  to ROM
- rom_dinp  out  DW  to ROM
- rom_wren  out  1  to ROM
- rom_enable  out  1  to ROM
- rom_dout  in  DW  from ROM; valid the cycle after rom_enable=1 with rom_wren=0
- busy  out  1  FSM is not in IDLE
- wp_violation  out  1  one-cycle pulse when a target write is dropped because of write_protect

Behaviour:
- All outputs are registered.
- Reset (rst_n = 0 at a clk edge): every output goes to 0; FSM goes to IDLE; round-robin pointer favours the target.
- Reset mid-operation: rom_enable and rom_wren drop on the next edge; the in-flight request gets no ack.

FSM states: IDLE, RD, RDW, MRD, MRDW, MWR, WR, DONE.

IDLE: grant on cycle N.
- Arbitration:
  - If both requesters are pending, grant the one not granted last time (round-robin).
  - A single pending requester is granted alone.
- Target with rom_bar_en = 0:
  - go to DONE;
  - t_rdata = 0;
  - writes are discarded;
  - no ROM access.
- Target write with write_protect = 1:
  - go to DONE;
  - pulse wp_violation;
  - no ROM access.
- Target write with t_be = 0: go to DONE with no ROM access.
- Any read: latch the address, go to RD.
- Full write (loader, or target with t_be = 4'hF): latch address and data, go to WR.
- Partial target write: latch address, data and byte enables, go to MRD.

Per-state actions:
- RD (N+1): rom_enable = 1, rom_wren = 0. Then RDW.
- RDW (N+2): capture rom_dout into the granted rdata register. Then DONE.
- MRD (N+1): rom_enable = 1, rom_wren = 0. Then MRDW.
- MRDW (N+2): merge per lane: lane k = t_be[k] ? new data : rom_dout. Then MWR.
- MWR (N+3): rom_enable = 1, rom_wren = 1, rom_dinp = merged word. Then DONE.
- WR (N+1): rom_enable = 1, rom_wren = 1, rom_dinp = write data. Then DONE.
- DONE: pulse the granted ack for exactly 1 cycle. Then IDLE.

Latency (grant cycle N to ack cycle):
- read: N+3
- full write: N+2
- RMW: N+4
- blocked / disabled / be = 0: N+1

Handshake:
- The requester keeps req, we, addr, be and data stable until it samples ack.
- The requester drops req in the cycle after ack.
- IDLE evaluates req again no earlier than the cycle after DONE, so a completed request is never re-granted.
- rdata holds its value until the next read by the same requester.

Other rules:
- rom_address holds its last value when rom_enable = 0.
- Requests are never queued or aborted. A request arriving while busy waits in IDLE arbitration.
- The loader ignores rom_bar_en and write_protect.

Test Plan:
- Loader writes 32'hAABBCCDD at address 0x005; target reads 0x005 with rom_bar_en = 1 -> target read t_ack at N+3, t_rdata = 32'hAABBCCDD, exactly one rom_enable cycle.
- Target writes 32'h11223344 with t_be = 4'b0101 to a word holding 32'hAABBCCDD -> rom_wren is seen only at N+3, stored word = 32'hAA22CC44, ack at N+4.
- Target writes with write_protect = 1, then target reads with rom_bar_en = 0 -> the write gives no rom_wren, wp_violation pulses once and ack comes at N+1; the read gives t_rdata = 0 with ack at N+1.
- t_req and l_req held high continuously for 6 transactions -> grants alternate L/T/L/T… after the first target grant, and no ack ever overlaps another ack.
- Full-word loader write at address 0x1FF (top of range) followed by a read at 0x000 -> no address wrap corruption; data read back is correct.
- rst_n driven to 0 in MRDW -> no rom_wren, no ack, all outputs 0 on the next edge; the next request after release completes normally.
